// File: rtl/mips_pkg.sv
// Shared constants and helpers for the pipelined MIPS core.
// Addresses are byte addresses; memories are organised as 32-bit words.
package mips_pkg;

    localparam int LENGTH            = 32;
    localparam int DEFAULT_MEM_DEPTH = 256;
    localparam logic [LENGTH-1:0] PC_INCREMENT = LENGTH'(4);

    // Drops the byte-offset bits; the caller keeps as many low bits as its memory needs.
    function automatic logic [LENGTH-1:0] byte_to_word(input logic [LENGTH-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Single-port word-organised instruction RAM: synchronous write, registered read.
// Zero-initialised at configuration; reset only clears the read register.
module instruction_memory
    import mips_pkg::*;
#(
    parameter  int WIDTH  = LENGTH,
    parameter  int DEPTH  = DEFAULT_MEM_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[addr] <= wr_data;
        end
    end

    // Output register carries the synchronous reset so the RAM array itself stays reset-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[addr];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, next-PC mux and the instruction memory.
// Memory is written only while the core is halted; fetches happen only while running.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter  int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LENGTH-1:0] pc_with_jump,
    input  logic              pc_enable,
    input  logic              jump,
    input  logic              mips_enable,
    input  logic              wr_memory_instruction_enable,
    input  logic [LENGTH-1:0] instruction_to_write,
    input  logic [LENGTH-1:0] address_to_write,
    output logic [LENGTH-1:0] program_counter,
    output logic [LENGTH-1:0] instruction
);

    logic [LENGTH-1:0] pc_reg;
    logic [LENGTH-1:0] pc_plus4;
    logic [LENGTH-1:0] pc_next;
    logic [LENGTH-1:0] pc_word;
    logic [LENGTH-1:0] wr_word;
    logic [ADDR_W-1:0] mem_addr;
    logic              fetch_en;
    logic              mem_wr_en;

    assign fetch_en  = mips_enable & pc_enable;
    assign mem_wr_en = wr_memory_instruction_enable & ~mips_enable;

    assign pc_plus4 = pc_reg + PC_INCREMENT;
    assign pc_next  = jump ? pc_with_jump : pc_plus4;

    // Upper address bits are dropped, so both PC and write addresses wrap around the memory.
    assign pc_word  = byte_to_word(pc_reg);
    assign wr_word  = byte_to_word(address_to_write);
    assign mem_addr = mips_enable ? pc_word[ADDR_W-1:0] : wr_word[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= '0;
            program_counter <= '0;
        end else if (fetch_en) begin
            pc_reg          <= pc_next;
            program_counter <= pc_plus4;
        end
    end

    instruction_memory #(
        .WIDTH (LENGTH),
        .DEPTH (MEM_DEPTH)
    ) u_instruction_memory (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .rd_en   (fetch_en),
        .addr    (mem_addr),
        .wr_data (instruction_to_write),
        .rd_data (instruction)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected outputs,
// a monitor pops and compares one entry after each clock edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_with_jump;
    logic        pc_enable;
    logic        jump;
    logic        mips_enable;
    logic        wr_memory_instruction_enable;
    logic [31:0] instruction_to_write;
    logic [31:0] address_to_write;
    logic [31:0] program_counter;
    logic [31:0] instruction;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch #(.MEM_DEPTH(256)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .pc_with_jump                 (pc_with_jump),
        .pc_enable                    (pc_enable),
        .jump                         (jump),
        .mips_enable                  (mips_enable),
        .wr_memory_instruction_enable (wr_memory_instruction_enable),
        .instruction_to_write         (instruction_to_write),
        .address_to_write             (address_to_write),
        .program_counter              (program_counter),
        .instruction                  (instruction)
    );

    // One cycle of stimulus, applied on the falling edge; the expectation is for the next rising edge.
    task automatic cyc(input logic rst, input logic me, input logic pe, input logic j,
                       input logic [31:0] pj, input logic we, input logic [31:0] wd,
                       input logic [31:0] wa, input logic [31:0] e_pc,
                       input logic [31:0] e_ins, input string name);
        exp_t e;
        @(negedge clk);
        reset                        = rst;
        mips_enable                  = me;
        pc_enable                    = pe;
        jump                         = j;
        pc_with_jump                 = pj;
        wr_memory_instruction_enable = we;
        instruction_to_write         = wd;
        address_to_write             = wa;
        e.pc   = e_pc;
        e.ins  = e_ins;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] e_pc, input logic [31:0] e_ins, input string name);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, e_pc, e_ins, name);
    endtask

    // Monitor: compares one scoreboard entry shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                if (program_counter !== e.pc || instruction !== e.ins) begin
                    n_err++;
                    $display("FAIL %s: got pc=%08h ins=%08h, expected pc=%08h ins=%08h",
                             e.name, program_counter, instruction, e.pc, e.ins);
                end else begin
                    $display("ok   %s: pc=%08h ins=%08h", e.name, program_counter, instruction);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, stimulus_done=%0d required 1", stim_done);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mips_enable = 1'b0; pc_enable = 1'b0; jump = 1'b0;
        pc_with_jump = '0; wr_memory_instruction_enable = 1'b0;
        instruction_to_write = '0; address_to_write = '0;

        cyc(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, "reset_state");

        // Load program while halted; jump/pc_enable must be ignored and outputs hold
        cyc(0, 0, 1, 1, 32'h40, 1, 32'h20010005, 32'h0, 32'h0, 32'h0, "load_w0_hold");
        cyc(0, 0, 1, 0, 32'h0,  1, 32'h20020003, 32'h4, 32'h0, 32'h0, "load_w1_hold");
        cyc(0, 0, 0, 0, 32'h0,  1, 32'h00221820, 32'h8, 32'h0, 32'h0, "load_w2_hold");

        // Run-mode writes must be blocked
        cyc(1, 1, 1, 0, 32'h0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, "blocked_wr_in_reset");
        cyc(0, 1, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, "blocked_wr_stalled");
        cyc(1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, "run_reset_pulse");

        fetch(32'd4, 32'h20010005, "fetch_0");
        fetch(32'd8, 32'h20020003, "fetch_1");
        cyc(0, 1, 1, 1, 32'h0, 0, 32'h0, 32'h0, 32'd12, 32'h00221820, "jump_edge_fetch_2");
        fetch(32'd4, 32'h20010005, "after_jump_mem0");

        // Stall: jump ignored while pc_enable=0
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 1, 32'h40, 0, 32'h0, 32'h0, 32'd4, 32'h20010005, $sformatf("stall_%0d", i));
        fetch(32'd8,  32'h20020003, "resume_mem1");
        fetch(32'd12, 32'h00221820, "resume_mem2");
        fetch(32'd16, 32'h00000000, "unwritten_0xc");
        fetch(32'd20, 32'h00000000, "unwritten_0x10");

        // Reset mid-run beats pc_enable and jump
        cyc(1, 1, 1, 1, 32'h80, 0, 32'h0, 32'h0, 32'h0, 32'h0, "midrun_reset");
        fetch(32'd4, 32'h20010005, "post_reset_mem0_intact");

        // Unaligned write lands in word 0; 0x3FC is the last word
        cyc(0, 0, 1, 1, 32'h80, 1, 32'h11111111, 32'h3,   32'd4, 32'h20010005, "load_unaligned_hold");
        cyc(0, 0, 0, 0, 32'h0,  1, 32'hCAFE0001, 32'h3FC, 32'd4, 32'h20010005, "load_last_hold");
        cyc(0, 1, 1, 1, 32'h400, 0, 32'h0, 32'h0, 32'd8, 32'h20020003, "jump_to_0x400");
        cyc(0, 1, 1, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 32'h404, 32'h11111111, "wrap_0x400_mem0");
        fetch(32'h0, 32'hCAFE0001, "pc_wrap_ffff_fffc");
        fetch(32'd4, 32'h11111111, "after_wrap_mem0");

        cyc(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'd4, 32'h11111111, "final_stall");

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and a word-organised instruction memory. The memory is loaded by an external programmer while the core is halted. While running, the block fetches one instruction per enabled cycle and presents it, together with the sequential next PC, to the IF/ID boundary.

Parameters:
LENGTH, 32, width of instructions, addresses and PC
MEM_DEPTH, 256, number of 32-bit words in instruction memory (power of two)
ADDR_W, log2(MEM_DEPTH) = 8, word-index width (derived, not overridden)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
pc_with_jump  in  32  branch/jump target byte address
pc_enable  in  1  1 = advance PC and fetch; 0 = stall (hold)
jump  in  1  1 = next PC taken from pc_with_jump
mips_enable  in  1  1 = run mode; 0 = halted/load mode
wr_memory_instruction_enable  in  1  write strobe for instruction memory (effective only in load mode)
instruction_to_write  in  32  word to store
address_to_write  in  32  byte address of the word to store
program_counter  out  32  registered PC+4 of the instruction on "instruction"
instruction  out  32  registered fetched instruction word

Behaviour:
- Internal register pc_q (32 b). Addresses are byte addresses; word index = addr[ADDR_W+1:2]. Bits [1:0] are ignored. Bits above ADDR_W+1 are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Reset (sync, highest priority): pc_q=0, program_counter=0, instruction=0. Memory contents are not affected. Reset asserted mid-run takes effect at the next edge regardless of the other inputs.
- Memory initialises to all zeros at elaboration/configuration.
- Load mode (mips_enable=0):
  - If wr_memory_instruction_enable=1: mem[address_to_write idx] <= instruction_to_write at the edge.
  - pc_q, program_counter and instruction hold.
- Run mode (mips_enable=1):
  - Memory writes are blocked even if wr_memory_instruction_enable=1.
  - If pc_enable=1, at each edge:
    - instruction <= mem[pc_q idx]
    - program_counter <= pc_q + 4
    - pc_q <= jump ? pc_with_jump : pc_q + 4
  - If pc_enable=0: all registers hold (stall). The jump input is ignored during a stall.
- Latency: one cycle from pc_q to the instruction output. The first fetch after reset yields mem[0] with program_counter=4.
- Arithmetic: PC+4 is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- Simultaneous events: reset beats everything. In load mode, jump and pc_enable are ignored. A read and a write never occur in the same cycle, so there is no read/write collision case.

Decomposition:
- Shared package mips_pkg:
  - LENGTH = 32
  - PC_INCREMENT = 4
  - default instruction memory depth
- One natural sub-module, instruction_memory:
  - single-port RAM, MEM_DEPTH x 32
  - synchronous write with write enable
  - synchronous registered read with read enable
  - zero-initialised
  - maps to block RAM
- instruction_fetch contains pc_q, next-PC mux, program_counter register and the write-enable gating (wr_memory_instruction_enable & ~mips_enable).

Test Plan:
1. Load then run:
   - mips_enable=0, write 0x20010005@0x0, 0x20020003@0x4, 0x00221820@0x8.
   - Then mips_enable=1, pc_enable=1, jump=0, pulse reset 1 cycle.
   - Consecutive edges give instruction=0x20010005/pc 4, 0x20020003/pc 8, 0x00221820/pc 12.
2. Jump:
   - pc_q=8, jump=1, pc_with_jump=0x0 for one edge.
   - The next fetch returns mem[0], and program_counter returns to 4.
3. Stall:
   - pc_enable=0 for 3 cycles mid-run.
   - instruction and program_counter stay constant; on release, the sequence resumes with no skipped word.
4. Write blocked in run mode:
   - mips_enable=1, wr_memory_instruction_enable=1, write 0xDEADBEEF@0x0.
   - After reset and refetch, address 0 still reads 0x20010005.
5. Reset mid-run:
   - After 5 fetches, assert reset.
   - Next edge gives pc 0, instruction 0. Memory is intact, so the subsequent fetch returns mem[0].
6. Wrap and unaligned:
   - Write 0x11111111@0x3 stores to index 0.
   - Fetch with pc_with_jump=MEM_DEPTH*4 (0x400) returns mem[0].
   - Unwritten location 0x10 reads 0x00000000.
